nap_timer: RTL
==============

# nap_timer

Countdown stage directly downstream of the main nap state machine. While the state machine holds `enSleep`, the block counts down the nap length latched from the setting stage at one-second resolution. When the count expires it returns `completeSleep`, which moves the state machine into the alarm state. It also drives the remaining minutes and seconds to the display.

## Interface
Parameters:
- `CLK_HZ`, default 1000: clock cycles per one-second tick; legal range 2..2^20.
- `MAX_MIN`, default 99: upper clamp for the nap length, in minutes.

Ports:
- `clock`  in  1  single system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserts on low, independent of `clock`).
- `enSleep`  in  1  level from the main state machine; high while it is in the sleep state.
- `enCancel`  in  1  level from the main state machine; high in the cancel state.
- `setMin`  in  7  nap length in minutes from the setting stage; sampled only on load.
- `completeSleep`  out  1  registered; high while the countdown has expired.
- `running`  out  1  registered; high while counting.
- `remMin`  out  7  remaining minutes, binary.
- `remSec`  out  6  remaining seconds, binary, range 0..59.

## Operation
- FSM states: `IDLE`, `COUNT`, `DONE`. Encoding: `IDLE`=0, `COUNT`=1, `DONE`=2.
- Reset values: state=`IDLE`, prescaler=0, `remMin`=0, `remSec`=0, `completeSleep`=0, `running`=0.
- **IDLE**
  - On an edge with `enSleep`=1 and `enCancel`=0: load `remMin`=clamp(`setMin`), `remSec`=0, prescaler=0, then go to `COUNT`.
  - clamp: values >`MAX_MIN` become `MAX_MIN`; 0 stays 0.
  - If the loaded value is 0:00, go to `DONE` instead of `COUNT`.
- **COUNT**
  - Prescaler counts 0..`CLK_HZ`-1 and wraps; the wrap edge is the tick.
  - On a tick: if `remSec`>0, decrement `remSec`; otherwise set `remSec`=59 and decrement `remMin`.
  - If the tick takes the count from 0:01 to 0:00, go to `DONE` on that same edge.
- **DONE**
  - `completeSleep`=1; the count holds at 0:00.
  - Return to `IDLE` when `enSleep`=0 and the main state machine has left sleep.
  - The remaining-time outputs keep 0:00 until the next load.
- **Abort:** in `COUNT` or `DONE`, `enCancel`=1 or `enSleep`=0 forces `IDLE` on the next edge. This clears the count to 0:00, clears the prescaler and drops `completeSleep`. `enCancel` takes priority over a simultaneous tick.
- **Re-entry:** a new load requires passing through `IDLE`. Holding `enSleep` high continuously never reloads.
- `running`=1 exactly when the state is `COUNT`.

## Timing
- Load latency: `running` rises on the same edge that samples `enSleep`=1 (edge E0).
- First decrement at edge E0+`CLK_HZ`; the k-th decrement at E0+k·`CLK_HZ`.
- `completeSleep` rises on edge E0+N·`CLK_HZ`, where N = minutes·60.
- Zero length: `completeSleep` rises at E0 directly.
- Abort latency: outputs reach their reset values on the first edge that samples the abort condition.
- Asynchronous `reset` low mid-count: immediate return to reset values. Counting resumes only after reset is released and a fresh load is sampled in `IDLE`.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `NAP_TIMER_PREWARN_EN`
  - Defined: adds output port `preWarn` (1 bit, registered, reset 0). High in `COUNT` while remaining time is ≤ 1:00 and > 0:00. Low in all other states, and low immediately on abort.
  - Undefined: the port and its logic are absent; all other behaviour is identical.

## Structure
- Shared package `nap_pkg`:
  - state enum for `IDLE`/`COUNT`/`DONE`;
  - constants `SEC_PER_MIN`=60 and `MIN_W`=7, `SEC_W`=6;
  - the default `MAX_MIN`.
- One sub-module `nap_tick_gen`: the prescaler, with synchronous clear input and a one-cycle `tick` output, parameterised by `CLK_HZ`.
- FSM and minute/second countdown in the top module.

## Test plan (CLK_HZ=4)
- Reset: `reset`=0 mid-count at 0:37 → all outputs 0 at once; after release with `enSleep`=1, a fresh load.
- Basic: `setMin`=1, `enSleep` raised at E0 → `running`=1 at E0; `remSec`=59 at E0+4; `completeSleep`=1 at E0+240, not at E0+236.
- Clamp and zero: `setMin`=120 → `remMin`=99 after load; `setMin`=0 → `completeSleep`=1 at E0, `running` stays 0.
- Cancel: `enCancel`=1 coincident with a tick at 0:01 → `IDLE`, `completeSleep` never asserts.
- Handback: in `DONE`, drop `enSleep` → `completeSleep`=0 next edge; raise `enSleep` again → reload from `setMin`.
- Prewarn (macro defined): `setMin`=2 → `preWarn` rises at E0+240, when the count reaches 1:00, and falls at E0+480 with `completeSleep` rising.

Source files
------------

// File: rtl/nap_pkg.sv
// Shared types and constants for the nap countdown timer.
package nap_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StCount = 2'd1,
    StDone  = 2'd2
  } nap_state_e;

  localparam int unsigned SEC_PER_MIN     = 60;
  localparam int unsigned MIN_W           = 7;
  localparam int unsigned SEC_W           = 6;
  localparam int unsigned MAX_MIN_DEFAULT = 99;

  // Limit a requested nap length to max_min minutes; zero passes through.
  function automatic logic [MIN_W-1:0] clamp_min(input logic [MIN_W-1:0] m,
                                                  input int unsigned       max_min);
    if (32'(m) > max_min) return MIN_W'(max_min);
    return m;
  endfunction

endpackage

// File: rtl/nap_tick_gen.sv
// One-second prescaler: counts 0..CLK_HZ-1 and flags the wrap cycle as a tick.
module nap_tick_gen #(
  parameter int unsigned CLK_HZ = 1000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CntW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_HZ - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            wrap;

  assign wrap   = (cnt_q == CntMax);
  // A clear wins over a coincident wrap so an abort never produces a tick.
  assign tick_o = wrap & ~clr_i;

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (clr_i || wrap) cnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/nap_timer.sv
// Nap countdown: loads a clamped minute count on sleep entry and counts down in seconds.
// Optional NAP_TIMER_PREWARN_EN adds a registered preWarn output for the last minute.
module nap_timer
  import nap_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 1000,
  parameter int unsigned MAX_MIN = MAX_MIN_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enSleep,
  input  logic             enCancel,
  input  logic [MIN_W-1:0] setMin,
  output logic             completeSleep,
  output logic             running,
  output logic [MIN_W-1:0] remMin,
  output logic [SEC_W-1:0] remSec
`ifdef NAP_TIMER_PREWARN_EN
  ,
  output logic             preWarn
`endif
);

  localparam logic [SEC_W-1:0] SecMax = SEC_W'(SEC_PER_MIN - 1);

  nap_state_e       st_q, st_d;
  logic [MIN_W-1:0] min_q, min_d;
  logic [SEC_W-1:0] sec_q, sec_d;
  logic             comp_q, comp_d;
  logic             run_q, run_d;
  logic             pre_d;
  logic             abort;
  logic             tick;

  assign abort = enCancel | ~enSleep;

  nap_tick_gen #(
    .CLK_HZ(CLK_HZ)
  ) u_tick_gen (
    .clk_i (clock),
    .rst_ni(reset),
    .clr_i ((st_q != StCount) | abort),
    .tick_o(tick)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) st_q <= StIdle;
    else        st_q <= st_d;
  end

  always_comb begin
    st_d  = st_q;
    min_d = min_q;
    sec_d = sec_q;
    unique case (st_q)
      StIdle: begin
        if (enSleep && !enCancel) begin
          min_d = clamp_min(setMin, MAX_MIN);
          sec_d = '0;
          st_d  = (min_d == '0) ? StDone : StCount;
        end
      end
      StCount: begin
        if (abort) begin
          st_d  = StIdle;
          min_d = '0;
          sec_d = '0;
        end else if (tick) begin
          if (sec_q != '0) begin
            sec_d = sec_q - SEC_W'(1);
          end else begin
            sec_d = SecMax;
            min_d = min_q - MIN_W'(1);
          end
          if (min_q == '0 && sec_q == SEC_W'(1)) st_d = StDone;
        end
      end
      StDone: begin
        if (abort) begin
          st_d  = StIdle;
          min_d = '0;
          sec_d = '0;
        end
      end
      default: begin
        st_d  = StIdle;
        min_d = '0;
        sec_d = '0;
      end
    endcase
  end

  // Flags are computed from the next state so they move on the same edge as the count.
  always_comb begin
    comp_d = (st_d == StDone);
    run_d  = (st_d == StCount);
    pre_d  = (st_d == StCount) &&
             ((min_d == '0) || (min_d == MIN_W'(1) && sec_d == '0));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      min_q  <= '0;
      sec_q  <= '0;
      comp_q <= 1'b0;
      run_q  <= 1'b0;
    end else begin
      min_q  <= min_d;
      sec_q  <= sec_d;
      comp_q <= comp_d;
      run_q  <= run_d;
    end
  end

  assign completeSleep = comp_q;
  assign running       = run_q;
  assign remMin        = min_q;
  assign remSec        = sec_q;

`ifdef NAP_TIMER_PREWARN_EN
  logic pre_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) pre_q <= 1'b0;
    else        pre_q <= pre_d;
  end

  assign preWarn = pre_q;
`else
  logic unused_pre;
  assign unused_pre = pre_d;
`endif

endmodule
